// File: rtl/mdu_alu_sequencer.sv
// Multi-cycle unsigned MUL/DIVU/REMU sequencer that time-shares the execute-stage ALU (ADD/SUB only).
// Optional macro MDU_EARLY_EXIT_EN: MUL finishes once the remaining multiplier bits are all zero.
module mdu_alu_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic [2:0]      alu_ctrl_o,
  input  logic [XLEN-1:0] alu_result_i
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  localparam logic [1:0]       OP_MUL   = 2'b00;
  localparam logic [1:0]       OP_DIVU  = 2'b01;
  localparam logic [1:0]       OP_REMU  = 2'b10;
  localparam logic [2:0]       ALU_ADD  = 3'b000;
  localparam logic [2:0]       ALU_SUB  = 3'b001;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [XLEN-1:0]   alu_a_q, alu_a_d;
  logic [XLEN-1:0]   alu_b_q, alu_b_d;
  logic [2:0]        alu_ctrl_q, alu_ctrl_d;

  logic [XLEN-1:0]   shifted;
  logic              top;
  logic              borrow;
  logic              take;
  logic              mul_last;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= ALU_ADD;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      divisor_q  <= divisor_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
    end
  end

  // Next state, datapath update and next-cycle ALU drive
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    divisor_d  = divisor_q;
    result_d   = result_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    alu_a_d    = '0;
    alu_b_d    = '0;
    alu_ctrl_d = ALU_ADD;
    mul_last   = 1'b0;

    shifted = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    top     = rem_q[XLEN-1];
    borrow  = (~shifted[XLEN-1] & divisor_q[XLEN-1]) |
              (~(shifted[XLEN-1] ^ divisor_q[XLEN-1]) & alu_result_i[XLEN-1]);
    take    = top | ~borrow;

    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          op_d      = op_i;
          cnt_d     = '0;
          acc_d     = '0;
          rem_d     = '0;
          mcand_d   = src_a_i;
          mplier_d  = src_b_i;
          quo_d     = src_a_i;
          divisor_d = src_b_i;
          case (op_i)
            OP_MUL: state_d = S_MUL;
            OP_DIVU, OP_REMU: begin
              if (src_b_i == '0) begin
                state_d  = S_DONE;
                result_d = (op_i == OP_DIVU) ? '1 : src_a_i;
              end else begin
                state_d = S_DIV;
              end
            end
            default: begin
              state_d  = S_DONE;
              result_d = '0;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d    = alu_result_i;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
`ifdef MDU_EARLY_EXIT_EN
        mul_last = (cnt_q == CNT_LAST) || (mplier_d == '0);
`else
        mul_last = (cnt_q == CNT_LAST);
`endif
        if (mul_last) begin
          state_d  = S_DONE;
          result_d = alu_result_i;
        end
      end
      S_DIV: begin
        rem_d = take ? alu_result_i : shifted;
        quo_d = {quo_q[XLEN-2:0], take};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          result_d = (op_q == OP_REMU) ? rem_d : quo_d;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort drops any pending result and returns to idle
    if (flush_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end

    busy_d = (state_d == S_MUL) || (state_d == S_DIV);
    done_d = (state_d == S_DONE);

    if (state_d == S_MUL) begin
      alu_ctrl_d = ALU_ADD;
      alu_a_d    = acc_d;
      alu_b_d    = mplier_d[0] ? mcand_d : '0;
    end else if (state_d == S_DIV) begin
      alu_ctrl_d = ALU_SUB;
      alu_a_d    = {rem_d[XLEN-2:0], quo_d[XLEN-1]};
      alu_b_d    = divisor_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign alu_a_o    = alu_a_q;
  assign alu_b_o    = alu_b_q;
  assign alu_ctrl_o = alu_ctrl_q;

endmodule

// File: tb/tb_mdu_alu_sequencer.sv
// Scoreboard bench for mdu_alu_sequencer with a behavioural ADD/SUB ALU attached.
module tb_mdu_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic [2:0]  alu_ctrl_o;
  logic [31:0] alu_result_i;

  int n_checks;
  int n_pass;
  logic [31:0] sb_q[$];
  string       tag_q[$];
  logic [31:0] last_res;

  mdu_alu_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .op_i         (op_i),
    .src_a_i      (src_a_i),
    .src_b_i      (src_b_i),
    .flush_i      (flush_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .result_o     (result_o),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_ctrl_o   (alu_ctrl_o),
    .alu_result_i (alu_result_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: only ADD and SUB are exercised
  always_comb alu_result_i = (alu_ctrl_o == 3'b001) ? (alu_a_o - alu_b_o) : (alu_a_o + alu_b_o);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic int mul_iters(input logic [31:0] b);
    int n;
`ifdef MDU_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
`else
    n = 32;
`endif
    return n;
  endfunction

  // Result scoreboard: pop one expected entry per done strobe
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        string t;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check_eq(t, result_o, e);
      end
    end
  end

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp_res;
    int          exp_lat, exp_busy, cyc, busy_cnt;
    logic [2:0]  exp_ctrl;
    logic        ctrl_ok;
    exp_ctrl = 3'b001;
    case (op)
      2'b00: begin
        exp_res  = a * b;
        exp_busy = mul_iters(b);
        exp_ctrl = 3'b000;
      end
      2'b01: begin
        exp_res  = (b == 0) ? 32'hFFFF_FFFF : a / b;
        exp_busy = (b == 0) ? 0 : 32;
      end
      2'b10: begin
        exp_res  = (b == 0) ? a : a % b;
        exp_busy = (b == 0) ? 0 : 32;
      end
      default: begin
        exp_res  = 32'd0;
        exp_busy = 0;
      end
    endcase
    exp_lat = exp_busy + 1;

    @(negedge clk);
    start_i = 1'b1;
    op_i    = op;
    src_a_i = a;
    src_b_i = b;
    sb_q.push_back(exp_res);
    tag_q.push_back({tag, "_result"});
    @(negedge clk);
    start_i  = 1'b0;
    cyc      = 1;
    busy_cnt = 0;
    ctrl_ok  = 1'b1;
    while (!done_o && cyc < 100) begin
      if (busy_o) begin
        busy_cnt++;
        if (alu_ctrl_o !== exp_ctrl) ctrl_ok = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check_eq({tag, "_alu_ctrl"}, {31'd0, ctrl_ok}, 32'd1);
    check_eq({tag, "_busy_at_done"}, {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    check_eq({tag, "_done_one_cycle"}, {31'd0, done_o}, 32'd0);
    check_eq({tag, "_result_hold"}, result_o, exp_res);
    last_res = exp_res;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    last_res = 32'd0;
    rst_n    = 1'b0;
    start_i  = 1'b0;
    op_i     = 2'b00;
    src_a_i  = 32'd0;
    src_b_i  = 32'd0;
    flush_i  = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_done", {31'd0, done_o}, 32'd0);
    check_eq("rst_result", result_o, 32'd0);
    check_eq("rst_alu_a", alu_a_o, 32'd0);
    check_eq("rst_alu_b", alu_b_o, 32'd0);
    check_eq("rst_alu_ctrl", {29'd0, alu_ctrl_o}, 32'd0);
    rst_n = 1'b1;

    run_op("mul_7x6",      2'b00, 32'd7,          32'd6);
    run_op("mul_ffff",     2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op("mul_wrap",     2'b00, 32'h0001_0000,  32'h0001_0000);
    run_op("divu_100_7",   2'b01, 32'd100,        32'd7);
    run_op("remu_100_7",   2'b10, 32'd100,        32'd7);
    run_op("divu_max_1",   2'b01, 32'hFFFF_FFFF,  32'd1);
    run_op("remu_big",     2'b10, 32'hDEAD_BEEF,  32'h0001_2345);
    run_op("divu_5_0",     2'b01, 32'd5,          32'd0);
    run_op("remu_5_0",     2'b10, 32'd5,          32'd0);
    run_op("reserved_op",  2'b11, 32'd9,          32'd4);

    // Flush mid-divide; a start pulse while busy must be ignored
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b01; src_a_i = 32'd100; src_b_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    start_i = 1'b1; op_i = 2'b00; src_a_i = 32'd3; src_b_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    check_eq("busy_start_ignored_ctrl", {29'd0, alu_ctrl_o}, 32'd1);
    check_eq("busy_start_ignored_busy", {31'd0, busy_o}, 32'd1);
    repeat (5) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check_eq("flush_busy", {31'd0, busy_o}, 32'd0);
    check_eq("flush_done", {31'd0, done_o}, 32'd0);
    check_eq("flush_alu_a", alu_a_o, 32'd0);
    check_eq("flush_result_kept", result_o, last_res);
    repeat (40) @(negedge clk);
    check_eq("flush_result_still_kept", result_o, last_res);

    // start and flush together in idle drop the request
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'b00; src_a_i = 32'd7; src_b_i = 32'd6;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    check_eq("start_flush_busy", {31'd0, busy_o}, 32'd0);
    repeat (40) @(negedge clk);
    check_eq("start_flush_result", result_o, last_res);

    // Asynchronous reset in the middle of a multiply
    start_i = 1'b1; op_i = 2'b00; src_a_i = 32'h1234_5678; src_b_i = 32'hFFFF_0001;
    @(negedge clk);
    start_i = 1'b0;
    repeat (19) @(negedge clk);
    check_eq("pre_reset_busy", {31'd0, busy_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("async_rst_done", {31'd0, done_o}, 32'd0);
    check_eq("async_rst_result", result_o, 32'd0);
    check_eq("async_rst_alu_a", alu_a_o, 32'd0);
    check_eq("async_rst_alu_b", alu_b_o, 32'd0);
    check_eq("async_rst_alu_ctrl", {29'd0, alu_ctrl_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mul_3x5", 2'b00, 32'd3, 32'd5);

    repeat (3) @(negedge clk);
    check_eq("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
